// File: rtl/axi4_lite_slave_regs_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes, FSM encodings
// and the byte-lane merge used by register writes.
package axi4_lite_slave_regs_pkg;

   typedef logic [1:0] axi_resp_t;

   localparam axi_resp_t RESP_OKAY   = 2'b00;
   localparam axi_resp_t RESP_SLVERR = 2'b10;
   localparam axi_resp_t RESP_DECERR = 2'b11;

   localparam logic [0:0] W_COLLECT = 1'b0;
   localparam logic [0:0] W_RESP    = 1'b1;

   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Maps a byte address onto a register index and flags addresses beyond the register bank.
module axi4_lite_addr_decode #(
   parameter int unsigned C_AXI_ADDR_WIDTH = 32,
   parameter int unsigned NUM_REGS         = 16
) (
   input  logic [C_AXI_ADDR_WIDTH-1:0]  addr,
   output logic                         in_range,
   output logic [$clog2(NUM_REGS)-1:0]  index
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);

   logic unused_byte_offset;

   assign index              = addr[IDX_W+1:2];
   assign in_range           = (addr[C_AXI_ADDR_WIDTH-1:IDX_W+2] == '0);
   assign unused_byte_offset = ^addr[1:0];

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave with NUM_REGS read/write registers and independent read/write paths.
// Define AXI4_LITE_SLAVE_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module axi4_lite_slave_regs
   import axi4_lite_slave_regs_pkg::*;
#(
   parameter int unsigned C_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_AXI_ADDR_WIDTH = 32,
   parameter int unsigned NUM_REGS         = 16
) (
   input  logic                                  CLK,
   input  logic                                  RESETN,
   input  logic [C_AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
   input  logic [2:0]                            S_AXI_AWPROT,
   input  logic                                  S_AXI_AWVALID,
   output logic                                  S_AXI_AWREADY,
   input  logic [C_AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
   input  logic [C_AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
   input  logic                                  S_AXI_WVALID,
   output logic                                  S_AXI_WREADY,
   output logic [1:0]                            S_AXI_BRESP,
   output logic                                  S_AXI_BVALID,
   input  logic                                  S_AXI_BREADY,
   input  logic [C_AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
   input  logic [2:0]                            S_AXI_ARPROT,
   input  logic                                  S_AXI_ARVALID,
   output logic                                  S_AXI_ARREADY,
   output logic [C_AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
   output logic [1:0]                            S_AXI_RRESP,
   output logic                                  S_AXI_RVALID,
   input  logic                                  S_AXI_RREADY,
   output logic [C_AXI_DATA_WIDTH*NUM_REGS-1:0]  REGS_OUT,
   output logic [NUM_REGS-1:0]                   WR_PULSE
);

   localparam int unsigned IDX_W  = $clog2(NUM_REGS);
   localparam int unsigned STRB_W = C_AXI_DATA_WIDTH / 8;

   // READYs stay low for the first cycle after reset release.
   logic rst_done_q;

   logic [0:0]                        w_state_q;
   logic                              have_aw_q, have_w_q;
   logic [C_AXI_ADDR_WIDTH-1:0]       awaddr_q;
   logic [C_AXI_DATA_WIDTH-1:0]       wdata_q;
   logic [STRB_W-1:0]                 wstrb_q;
   logic                              bvalid_q;
   axi_resp_t                         bresp_q;
   logic [NUM_REGS-1:0]               wr_pulse_q;
   logic [NUM_REGS-1:0][C_AXI_DATA_WIDTH-1:0] regs_q;

   logic [0:0]                        r_state_q;
   logic                              rvalid_q;
   logic [C_AXI_DATA_WIDTH-1:0]       rdata_q;
   axi_resp_t                         rresp_q;

   logic                              awready, wready, arready;
   logic                              aw_hs, w_hs, ar_hs, wr_fire;
   logic [C_AXI_ADDR_WIDTH-1:0]       wr_addr;
   logic [C_AXI_DATA_WIDTH-1:0]       wr_data;
   logic [STRB_W-1:0]                 wr_strb;
   logic                              wr_in_range, rd_in_range;
   logic [IDX_W-1:0]                  wr_idx, rd_idx;
   axi_resp_t                         wr_resp, rd_resp;
   logic [C_AXI_DATA_WIDTH-1:0]       rd_value;
   logic                              unused_bits;

   assign awready = rst_done_q && (w_state_q == W_COLLECT) && !have_aw_q;
   assign wready  = rst_done_q && (w_state_q == W_COLLECT) && !have_w_q;
   assign arready = rst_done_q && (r_state_q == R_IDLE);
   assign aw_hs   = S_AXI_AWVALID && awready;
   assign w_hs    = S_AXI_WVALID && wready;
   assign ar_hs   = S_AXI_ARVALID && arready;
   assign wr_fire = (have_aw_q || aw_hs) && (have_w_q || w_hs);

   // A held payload takes precedence; otherwise the one handshaking this cycle is used.
   assign wr_addr = have_aw_q ? awaddr_q : S_AXI_AWADDR;
   assign wr_data = have_w_q ? wdata_q : S_AXI_WDATA;
   assign wr_strb = have_w_q ? wstrb_q : S_AXI_WSTRB;

   axi4_lite_addr_decode #(
      .C_AXI_ADDR_WIDTH (C_AXI_ADDR_WIDTH),
      .NUM_REGS         (NUM_REGS)
   ) u_wr_decode (
      .addr     (wr_addr),
      .in_range (wr_in_range),
      .index    (wr_idx)
   );

   axi4_lite_addr_decode #(
      .C_AXI_ADDR_WIDTH (C_AXI_ADDR_WIDTH),
      .NUM_REGS         (NUM_REGS)
   ) u_rd_decode (
      .addr     (S_AXI_ARADDR),
      .in_range (rd_in_range),
      .index    (rd_idx)
   );

`ifdef AXI4_LITE_SLAVE_DECERR_EN
   assign wr_resp = wr_in_range ? RESP_OKAY : RESP_DECERR;
   assign rd_resp = rd_in_range ? RESP_OKAY : RESP_DECERR;
`else
   assign wr_resp = RESP_OKAY;
   assign rd_resp = RESP_OKAY;
`endif

   assign rd_value = rd_in_range ? regs_q[rd_idx] : '0;

   always_ff @(posedge CLK) begin
      if (!RESETN) rst_done_q <= 1'b0;
      else         rst_done_q <= 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         w_state_q  <= W_COLLECT;
         have_aw_q  <= 1'b0;
         have_w_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         regs_q     <= '0;
      end else begin
         wr_pulse_q <= '0;
         if (w_state_q == W_COLLECT) begin
            if (wr_fire) begin
               have_aw_q <= 1'b0;
               have_w_q  <= 1'b0;
               if (wr_in_range) begin
                  regs_q[wr_idx]     <= merge_strb(regs_q[wr_idx], wr_data, wr_strb);
                  wr_pulse_q[wr_idx] <= 1'b1;
               end
               bresp_q   <= wr_resp;
               bvalid_q  <= 1'b1;
               w_state_q <= W_RESP;
            end else begin
               if (aw_hs) begin
                  have_aw_q <= 1'b1;
                  awaddr_q  <= S_AXI_AWADDR;
               end
               if (w_hs) begin
                  have_w_q <= 1'b1;
                  wdata_q  <= S_AXI_WDATA;
                  wstrb_q  <= S_AXI_WSTRB;
               end
            end
         end else if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_COLLECT;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         r_state_q <= R_IDLE;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else if (r_state_q == R_IDLE) begin
         if (ar_hs) begin
            rdata_q   <= rd_value;
            rresp_q   <= rd_resp;
            rvalid_q  <= 1'b1;
            r_state_q <= R_DATA;
         end
      end else if (S_AXI_RREADY) begin
         rvalid_q  <= 1'b0;
         r_state_q <= R_IDLE;
      end
   end

   assign S_AXI_AWREADY = awready;
   assign S_AXI_WREADY  = wready;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign REGS_OUT      = regs_q;
   assign WR_PULSE      = wr_pulse_q;

   // PROT is ignored and SLVERR is never generated.
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, RESP_SLVERR};

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Randomised and directed bench for axi4_lite_slave_regs against a queue-based reference model.
module tb_axi4_lite_slave_regs;

   localparam int NREGS = 16;

   logic              CLK = 1'b0;
   logic              RESETN;
   logic [31:0]       S_AXI_AWADDR;
   logic [2:0]        S_AXI_AWPROT;
   logic              S_AXI_AWVALID;
   logic              S_AXI_AWREADY;
   logic [31:0]       S_AXI_WDATA;
   logic [3:0]        S_AXI_WSTRB;
   logic              S_AXI_WVALID;
   logic              S_AXI_WREADY;
   logic [1:0]        S_AXI_BRESP;
   logic              S_AXI_BVALID;
   logic              S_AXI_BREADY;
   logic [31:0]       S_AXI_ARADDR;
   logic [2:0]        S_AXI_ARPROT;
   logic              S_AXI_ARVALID;
   logic              S_AXI_ARREADY;
   logic [31:0]       S_AXI_RDATA;
   logic [1:0]        S_AXI_RRESP;
   logic              S_AXI_RVALID;
   logic              S_AXI_RREADY;
   logic [32*NREGS-1:0] REGS_OUT;
   logic [NREGS-1:0]  WR_PULSE;

   always #5 CLK = ~CLK;

   axi4_lite_slave_regs #(
      .C_AXI_DATA_WIDTH (32),
      .C_AXI_ADDR_WIDTH (32),
      .NUM_REGS         (NREGS)
   ) dut (
      .CLK           (CLK),
      .RESETN        (RESETN),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .REGS_OUT      (REGS_OUT),
      .WR_PULSE      (WR_PULSE)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit [31:0]      m_regs [NREGS];
   bit [31:0]      m_awq [$];
   bit [35:0]      m_wq [$];
   bit             m_bvalid, m_rvalid;
   bit [1:0]       m_bresp, m_rresp;
   bit [31:0]      m_rdata;
   bit [NREGS-1:0] m_pulse;
   int             m_live;

   function automatic bit in_rng(input bit [31:0] a);
      return a < 32'(NREGS * 4);
   endfunction

   function automatic bit [1:0] exp_resp(input bit [31:0] a);
`ifdef AXI4_LITE_SLAVE_DECERR_EN
      return in_rng(a) ? 2'b00 : 2'b11;
`else
      return 2'b00;
`endif
   endfunction

   function automatic bit m_awready();
      return m_live > 0 && !m_bvalid && m_awq.size() == 0;
   endfunction
   function automatic bit m_wready();
      return m_live > 0 && !m_bvalid && m_wq.size() == 0;
   endfunction
   function automatic bit m_arready();
      return m_live > 0 && !m_rvalid;
   endfunction

   always @(posedge CLK) begin : model
      bit awr, wr, arr;
      bit [31:0] a;
      bit [35:0] wd;
      int idx;
      if (!RESETN) begin
         foreach (m_regs[i]) m_regs[i] = '0;
         m_awq.delete();
         m_wq.delete();
         m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
         m_pulse = '0; m_live = 0;
      end else begin
         awr = m_awready(); wr = m_wready(); arr = m_arready();
         m_pulse = '0;
         // Reads sample the bank before any write landing on this edge.
         if (m_rvalid && S_AXI_RREADY) m_rvalid = 0;
         else if (S_AXI_ARVALID && arr) begin
            m_rdata  = in_rng(S_AXI_ARADDR) ? m_regs[S_AXI_ARADDR / 4] : 32'h0;
            m_rresp  = exp_resp(S_AXI_ARADDR);
            m_rvalid = 1;
         end
         if (m_bvalid && S_AXI_BREADY) m_bvalid = 0;
         if (S_AXI_AWVALID && awr) m_awq.push_back(S_AXI_AWADDR);
         if (S_AXI_WVALID && wr) m_wq.push_back({S_AXI_WSTRB, S_AXI_WDATA});
         if (m_awq.size() > 0 && m_wq.size() > 0) begin
            a  = m_awq.pop_front();
            wd = m_wq.pop_front();
            if (in_rng(a)) begin
               idx = int'(a / 4);
               for (int b = 0; b < 4; b++)
                  if (wd[32+b]) m_regs[idx][8*b +: 8] = wd[8*b +: 8];
               m_pulse[idx] = 1'b1;
            end
            m_bresp  = exp_resp(a);
            m_bvalid = 1;
         end
         if (m_live == 0) m_live = 1;
      end
   end

   always @(negedge CLK) begin : compare
      logic [511:0] flat;
      if (check_en) begin
         for (int i = 0; i < NREGS; i++) flat[32*i +: 32] = m_regs[i];
         chk("awready", S_AXI_AWREADY, m_awready());
         chk("wready", S_AXI_WREADY, m_wready());
         chk("arready", S_AXI_ARREADY, m_arready());
         chk("bvalid", S_AXI_BVALID, m_bvalid);
         chk("bresp", S_AXI_BRESP, m_bresp);
         chk("rvalid", S_AXI_RVALID, m_rvalid);
         chk("rdata", S_AXI_RDATA, m_rdata);
         chk("rresp", S_AXI_RRESP, m_rresp);
         chk("regs_out", REGS_OUT, flat);
         chk("wr_pulse", WR_PULSE, m_pulse);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic axi_write(input bit [31:0] addr, input bit [31:0] data, input bit [3:0] strb,
                            input int aw_dly, input int w_dly);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int c = 0;
      while (!(aw_done && w_done) && c < 64) begin
         if (c == aw_dly && !aw_done) begin S_AXI_AWVALID = 1; S_AXI_AWADDR = addr; end
         if (c == w_dly && !w_done) begin
            S_AXI_WVALID = 1; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
         end
         @(negedge CLK);
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         tick();
         if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 0; end
         if (w_hs) begin w_done = 1; S_AXI_WVALID = 0; end
         c++;
      end
      chk("write_handshakes", aw_done && w_done, 1);
   endtask

   task automatic ar_issue(input bit [31:0] addr);
      bit hs = 0;
      int c = 0;
      S_AXI_ARVALID = 1; S_AXI_ARADDR = addr;
      while (!hs && c < 32) begin
         @(negedge CLK); hs = S_AXI_ARREADY; tick(); c++;
      end
      S_AXI_ARVALID = 0;
      chk("ar_handshake", hs, 1);
   endtask

   task automatic axi_read(input bit [31:0] addr, output bit [31:0] data, output bit [1:0] resp);
      bit hs = 0;
      int c = 0;
      ar_issue(addr);
      while (!hs && c < 32) begin
         @(negedge CLK);
         hs = S_AXI_RVALID && S_AXI_RREADY; data = S_AXI_RDATA; resp = S_AXI_RRESP;
         tick(); c++;
      end
      chk("r_handshake", hs, 1);
   endtask

   function automatic bit [31:0] rand_addr();
      case ($urandom_range(0, 7))
         0:       return 32'h100;
         1:       return $urandom;
         default: return 32'($urandom_range(0, NREGS-1) * 4 + $urandom_range(0, 3));
      endcase
   endfunction

   bit [31:0] rd;
   bit [1:0]  rr;
   bit [1:0]  oor_resp;

   initial begin
`ifdef AXI4_LITE_SLAVE_DECERR_EN
      oor_resp = 2'b11;
`else
      oor_resp = 2'b00;
`endif
      RESETN = 0;
      S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
      S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 1;
      S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
      tick();
      check_en = 1;
      tick();
      @(negedge CLK);
      chk("reset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                            S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, WR_PULSE}, 0);
      chk("reset_regs", REGS_OUT, 0);
      tick();
      RESETN = 1;
      @(negedge CLK);
      chk("ready_first_cycle", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
      tick();
      @(negedge CLK);
      chk("ready_second_cycle", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
      tick();

      // Concurrent AW+W
      axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0);
      @(negedge CLK);
      chk("concurrent_reg2", REGS_OUT[95:64], 32'hDEADBEEF);
      chk("concurrent_pulse", WR_PULSE, 16'h0004);
      chk("concurrent_bvalid_bresp", {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
      tick();
      @(negedge CLK);
      chk("pulse_one_cycle", WR_PULSE, 16'h0000);
      tick();

      // W three cycles ahead of AW, then AW ahead of W
      axi_write(32'h0C, 32'h12345678, 4'hF, 3, 0);
      @(negedge CLK);
      chk("w_first_reg3", REGS_OUT[127:96], 32'h12345678);
      tick();
      axi_write(32'h0C, 32'h87654321, 4'hF, 0, 3);
      @(negedge CLK);
      chk("aw_first_reg3", REGS_OUT[127:96], 32'h87654321);
      tick();

      // Byte enables, including an all-zero strobe
      axi_write(32'h04, 32'hFFFFFFFF, 4'hF, 0, 0);
      tick();
      axi_write(32'h04, 32'h00000000, 4'h5, 0, 0);
      @(negedge CLK);
      chk("strb5_reg1", REGS_OUT[63:32], 32'hFF00FF00);
      tick();
      axi_write(32'h04, 32'h12345678, 4'h0, 1, 0);
      @(negedge CLK);
      chk("strb0_reg1", REGS_OUT[63:32], 32'hFF00FF00);
      chk("strb0_pulse", WR_PULSE, 16'h0002);
      tick();

      // Read backpressure
      S_AXI_RREADY = 0;
      ar_issue(32'h08);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("rbp_hold", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RDATA}, {2'b10, 32'hDEADBEEF});
         tick();
      end
      S_AXI_RREADY = 1;
      tick();

      // Write response backpressure
      S_AXI_BREADY = 0;
      axi_write(32'h14, 32'hA5A5A5A5, 4'hF, 0, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("bbp_hold", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b100);
         tick();
      end
      S_AXI_BREADY = 1;
      tick();

      // Out of range
      axi_write(32'h100, 32'hCAFEF00D, 4'hF, 0, 0);
      @(negedge CLK);
      chk("oor_write", {S_AXI_BVALID, S_AXI_BRESP, WR_PULSE}, {1'b1, oor_resp, 16'h0});
      tick();
      axi_read(32'h100, rd, rr);
      chk("oor_read", {rd, rr}, {32'h0, oor_resp});

      // Same-register read and write on one edge returns the old value
      S_AXI_AWVALID = 1; S_AXI_AWADDR = 32'h08; S_AXI_WVALID = 1;
      S_AXI_WDATA = 32'h11111111; S_AXI_WSTRB = 4'hF;
      S_AXI_ARVALID = 1; S_AXI_ARADDR = 32'h08;
      tick();
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
      @(negedge CLK);
      chk("collide_old_read", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, 32'hDEADBEEF});
      chk("collide_new_reg2", REGS_OUT[95:64], 32'h11111111);
      tick();
      tick();

      // Reset between AW and W
      S_AXI_AWVALID = 1; S_AXI_AWADDR = 32'h04;
      tick();
      S_AXI_AWVALID = 0;
      RESETN = 0;
      tick();
      tick();
      @(negedge CLK);
      chk("midwrite_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                             S_AXI_RVALID, S_AXI_RDATA, WR_PULSE, REGS_OUT}, 0);
      tick();
      RESETN = 1;
      tick();
      tick();
      axi_write(32'h00, 32'h5A5A5A5A, 4'hF, 2, 0);
      @(negedge CLK);
      chk("after_reset_write", {REGS_OUT[63:0]}, {32'h0, 32'h5A5A5A5A});
      tick();

      // Random traffic on all channels
      for (int c = 0; c < 1500; c++) begin
         bit aw_hs, w_hs, ar_hs;
         if (c == 700) begin
            S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
            RESETN = 0;
            tick();
            tick();
            RESETN = 1;
         end
         @(negedge CLK);
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
         tick();
         if (aw_hs) S_AXI_AWVALID = 0;
         if (w_hs) S_AXI_WVALID = 0;
         if (ar_hs) S_AXI_ARVALID = 0;
         if (!S_AXI_AWVALID && $urandom_range(0, 2) == 0) begin
            S_AXI_AWVALID = 1; S_AXI_AWADDR = rand_addr();
         end
         if (!S_AXI_WVALID && $urandom_range(0, 2) == 0) begin
            S_AXI_WVALID = 1; S_AXI_WDATA = $urandom; S_AXI_WSTRB = 4'($urandom_range(0, 15));
         end
         if (!S_AXI_ARVALID && $urandom_range(0, 2) == 0) begin
            S_AXI_ARVALID = 1; S_AXI_ARADDR = rand_addr();
         end
         S_AXI_BREADY = ($urandom_range(0, 3) != 0);
         S_AXI_RREADY = ($urandom_range(0, 3) != 0);
      end

      S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
      S_AXI_BREADY = 1; S_AXI_RREADY = 1;
      repeat (5) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
